// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem
// request at a time and feeds the IF/ID register consumed by decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold_pc,
    input  logic        i_hold_if,
    input  logic        i_br,
    input  logic [31:0] i_pc_branch,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_inst_id,
    output logic        o_flush_id
);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_pc_id;
    logic [31:0] r_inst_id;
    logic        r_flush_id;

    logic        w_req;
    logic        w_load;
    logic        w_rsp;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic [31:0] w_load_inst;

    assign w_target    = i_pc_branch & ~32'd3;
    assign w_pc_next   = r_fetch_pc + 32'd4;
    assign w_rsp       = i_imem_valid & ((r_state == S_WAIT) | (r_state == S_DROP));
    assign w_req       = (r_state == S_ISSUE) & ~i_hold_pc & ~i_br & ~i_rst;
    // A new instruction enters IF/ID from a live response or from the skid.
    assign w_load      = ~i_br & ~i_hold_if &
                         (((r_state == S_WAIT) & i_imem_valid) | (r_state == S_FULL));
    assign w_load_inst = (r_state == S_FULL) ? r_skid_inst : i_imem_rdata;

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_pc_id     = r_pc_id;
    assign o_inst_id   = r_inst_id;
    assign o_flush_id  = r_flush_id;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_ISSUE;
            r_fetch_pc  <= RESET_PC;
            r_skid_inst <= 32'd0;
        end else if (i_br) begin
            r_fetch_pc <= w_target;
            // An in-flight response must still drain before a new request.
            if (((r_state == S_WAIT) | (r_state == S_DROP)) & ~i_imem_valid)
                r_state <= S_DROP;
            else
                r_state <= S_ISSUE;
        end else begin
            if (w_load)
                r_fetch_pc <= w_pc_next;
            case (r_state)
                S_ISSUE: if (w_req) r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_imem_valid) begin
                        if (i_hold_if) begin
                            r_skid_inst <= i_imem_rdata;
                            r_state     <= S_FULL;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DROP:  if (w_rsp) r_state <= S_ISSUE;
                S_FULL:  if (~i_hold_if) r_state <= S_ISSUE;
                default: r_state <= S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc_id    <= 32'd0;
            r_inst_id  <= 32'd0;
            r_flush_id <= 1'b1;
        end else if (w_load) begin
            r_pc_id    <= w_pc_next;
            r_inst_id  <= w_load_inst;
            r_flush_id <= 1'b0;
        end else if (i_br | ~i_hold_if) begin
            r_flush_id <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed plan steps plus random traffic,
// all checked every cycle against a flag-based behavioural model.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hold_pc, hold_if, br, imem_valid;
    logic [31:0] pc_branch, imem_rdata;
    logic        imem_req, flush_id;
    logic [31:0] imem_addr, pc_id, inst_id;

    logic        d2_rst, d2_valid;
    logic [31:0] d2_rdata;
    logic        d2_req, d2_flush;
    logic [31:0] d2_addr, d2_pc_id, d2_inst;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_hold_pc(hold_pc), .i_hold_if(hold_if),
        .i_br(br), .i_pc_branch(pc_branch), .o_imem_req(imem_req),
        .o_imem_addr(imem_addr), .i_imem_valid(imem_valid),
        .i_imem_rdata(imem_rdata), .o_pc_id(pc_id), .o_inst_id(inst_id),
        .o_flush_id(flush_id)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .i_clk(clk), .i_rst(d2_rst), .i_hold_pc(1'b0), .i_hold_if(1'b0),
        .i_br(1'b0), .i_pc_branch(32'd0), .o_imem_req(d2_req),
        .o_imem_addr(d2_addr), .i_imem_valid(d2_valid),
        .i_imem_rdata(d2_rdata), .o_pc_id(d2_pc_id), .o_inst_id(d2_inst),
        .o_flush_id(d2_flush)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] m_pc, m_buf, m_id_pc, m_id_inst, mem_addr;
    bit          m_id_flush, m_pend, m_stale, m_buf_full;
    int          mem_cnt;
    int          lat;

    logic        obs_req, obs_flush;
    logic [31:0] obs_addr, obs_pc, obs_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008_0005;
        if (a == 32'd4) return 32'hAC09_0004;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 32'h0;
        m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_flush = 1'b1;
        m_pend = 1'b0; m_stale = 1'b0; m_buf_full = 1'b0;
        mem_cnt = 0;
    endtask

    task automatic cyc(input bit r, input bit hp, input bit hi, input bit b,
                       input logic [31:0] tgt, input bit spur);
        bit          v, got, exp_req, loaded;
        logic [31:0] li;
        @(negedge clk);
        v = (mem_cnt == 1);
        rst = r; hold_pc = hp; hold_if = hi; br = b; pc_branch = tgt;
        if (v) begin
            imem_valid = 1'b1; imem_rdata = mem_word(mem_addr);
        end else if (spur && !m_pend) begin
            imem_valid = 1'b1; imem_rdata = $urandom;
        end else begin
            imem_valid = 1'b0; imem_rdata = $urandom;
        end
        #1;
        obs_req = imem_req; obs_addr = imem_addr;
        obs_pc = pc_id; obs_inst = inst_id; obs_flush = flush_id;
        exp_req = !m_pend && !m_buf_full && !hp && !b && !r;
        chk("imem_req", {31'd0, obs_req}, {31'd0, exp_req});
        chk("imem_addr", obs_addr, m_pc);
        chk("pc_id", obs_pc, m_id_pc);
        chk("inst_id", obs_inst, m_id_inst);
        chk("flush_id", {31'd0, obs_flush}, {31'd0, m_id_flush});
        got = imem_valid && m_pend;
        if (mem_cnt > 0) mem_cnt--;
        if (r) begin
            model_reset();
        end else if (b) begin
            if (m_pend && !got) m_stale = 1'b1;
            else begin m_pend = 1'b0; m_stale = 1'b0; end
            m_buf_full = 1'b0;
            m_pc = tgt & ~32'd3;
            m_id_flush = 1'b1;
        end else begin
            loaded = 1'b0; li = 32'd0;
            if (exp_req) begin
                m_pend = 1'b1; m_stale = 1'b0;
                mem_cnt = lat; mem_addr = m_pc;
            end else if (got) begin
                m_pend = 1'b0;
                if (m_stale) m_stale = 1'b0;
                else if (!hi) begin loaded = 1'b1; li = imem_rdata; end
                else begin m_buf_full = 1'b1; m_buf = imem_rdata; end
            end else if (m_buf_full && !hi) begin
                loaded = 1'b1; li = m_buf; m_buf_full = 1'b0;
            end
            if (loaded) begin
                m_id_pc = m_pc + 32'd4; m_id_inst = li;
                m_id_flush = 1'b0; m_pc = m_pc + 32'd4;
            end else if (!hi) begin
                m_id_flush = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0;
        pc_branch = 32'd0; imem_valid = 1'b0; imem_rdata = 32'd0;
        d2_rst = 1'b1; d2_valid = 1'b0; d2_rdata = 32'd0;
        lat = 1;
        @(negedge clk);
        model_reset();

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("first_req", {31'd0, obs_req}, 32'd1);
        chk("first_addr", obs_addr, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rsp_flush_before", {31'd0, obs_flush}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("first_inst", obs_inst, 32'h2008_0005);
        chk("first_pc_id", obs_pc, 32'h4);
        chk("first_flush", {31'd0, obs_flush}, 32'd0);
        chk("second_addr", obs_addr, 32'h4);

        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("full_no_req", {31'd0, obs_req}, 32'd0);
        chk("full_keep_inst", obs_inst, 32'h2008_0005);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("skid_inst", obs_inst, 32'hAC09_0004);
        chk("skid_pc_id", obs_pc, 32'h8);
        chk("hold_pc_req0", {31'd0, obs_req}, 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("hold_pc_req1", {31'd0, obs_req}, 32'd0);
        chk("hold_pc_flush", {31'd0, obs_flush}, 32'd1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("hold_pc_req2", {31'd0, obs_req}, 32'd0);
        lat = 3;
        cyc(0, 0, 0, 0, 0, 0);
        chk("release_req", {31'd0, obs_req}, 32'd1);
        chk("release_addr", obs_addr, 32'h8);

        cyc(0, 0, 0, 1, 32'h43, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drop_no_req", {31'd0, obs_req}, 32'd0);
        lat = 1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("stale_no_req", {31'd0, obs_req}, 32'd0);
        chk("stale_flush", {31'd0, obs_flush}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("target_req", {31'd0, obs_req}, 32'd1);
        chk("target_addr", obs_addr, 32'h40);

        cyc(0, 0, 0, 1, 32'h100, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("br_valid_req", {31'd0, obs_req}, 32'd1);
        chk("br_valid_addr", obs_addr, 32'h100);
        chk("br_valid_flush", {31'd0, obs_flush}, 32'd1);

        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(1, 4);
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom, $urandom_range(0, 19) == 0);
        end
        rst = 1'b1;

        @(negedge clk);
        d2_rst = 1'b0;
        #1;
        chk("wrap_req0", {31'd0, d2_req}, 32'd1);
        chk("wrap_addr0", d2_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        d2_valid = 1'b1; d2_rdata = 32'h1111_1111;
        #1;
        chk("wrap_wait_req", {31'd0, d2_req}, 32'd0);
        @(negedge clk);
        d2_valid = 1'b0;
        #1;
        chk("wrap_pc_id", d2_pc_id, 32'h0);
        chk("wrap_inst", d2_inst, 32'h1111_1111);
        chk("wrap_flush", {31'd0, d2_flush}, 32'd0);
        chk("wrap_addr1", d2_addr, 32'h0);
        chk("wrap_req1", {31'd0, d2_req}, 32'd1);
        @(negedge clk);
        d2_rst = 1'b1;
        #1;
        chk("rst_gates_req", {31'd0, d2_req}, 32'd0);
        @(negedge clk);
        d2_rst = 1'b0;
        #1;
        chk("rst_mid_addr", d2_addr, 32'hFFFF_FFFC);
        chk("rst_mid_flush", {31'd0, d2_flush}, 32'd1);
        chk("rst_mid_pc_id", d2_pc_id, 32'h0);
        chk("rst_mid_req", {31'd0, d2_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
